// File: rtl/fp32_pkg.sv
// FP32 field layout, special-value constants and classification helpers
// shared by the neuron datapath arithmetic blocks.
package fp32_pkg;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    localparam logic [31:0] QNAN     = 32'h7FC00000;
    localparam logic [31:0] POS_INF  = 32'h7F800000;
    localparam logic [31:0] NEG_INF  = 32'hFF800000;
    localparam int          EXP_BIAS = 127;
    localparam logic [7:0]  EXP_MAX  = 8'hFF;

    function automatic logic is_nan(input logic [31:0] v);
        return (v[30:23] == EXP_MAX) && (v[22:0] != '0);
    endfunction

    function automatic logic is_inf(input logic [31:0] v);
        return (v[30:23] == EXP_MAX) && (v[22:0] == '0);
    endfunction

    // Denormals count as zero: they are flushed before any arithmetic.
    function automatic logic is_zero(input logic [31:0] v);
        return v[30:23] == 8'h00;
    endfunction

endpackage

// File: rtl/fp32_adder.sv
// Combinational FP32 adder: flush-to-zero, 3 guard bits, truncating rounding,
// NaN/inf propagation. One result per cycle, no state.
module fp32_adder
    import fp32_pkg::*;
(
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] sum
);

    fp32_t              fa, fb, big, sml;
    logic               a_ge_b;
    logic               eff_sub;
    logic               found;
    logic [7:0]         diff;
    logic [26:0]        big_m, sml_m;
    logic [27:0]        raw, norm;
    logic [4:0]         lz;
    logic signed [9:0]  exp_r;
    logic               unused_norm;

    always_comb begin
        fa      = a;
        fb      = b;
        a_ge_b  = {fa.exp, fa.frac} >= {fb.exp, fb.frac};
        big     = a_ge_b ? fa : fb;
        sml     = a_ge_b ? fb : fa;
        diff    = big.exp - sml.exp;
        big_m   = {1'b1, big.frac, 3'b000};
        sml_m   = (diff >= 8'd26) ? '0 : ({1'b1, sml.frac, 3'b000} >> diff);
        eff_sub = big.sign ^ sml.sign;
        raw     = eff_sub ? ({1'b0, big_m} - {1'b0, sml_m})
                          : ({1'b0, big_m} + {1'b0, sml_m});

        // Leading-zero count over the 28-bit raw sum; bit 27 is the carry-out.
        lz    = '0;
        found = 1'b0;
        for (int i = 27; i >= 0; i--) begin
            if (!found && raw[i]) begin
                lz    = 5'(27 - i);
                found = 1'b1;
            end
        end
        norm  = raw << lz;
        exp_r = $signed({2'b00, big.exp}) + 10'sd1 - $signed({5'b00000, lz});

        if (is_nan(a) || is_nan(b))
            sum = QNAN;
        else if (is_inf(a) && is_inf(b))
            sum = (fa.sign != fb.sign) ? QNAN : a;
        else if (is_inf(a))
            sum = a;
        else if (is_inf(b))
            sum = b;
        else if (is_zero(a) && is_zero(b))
            sum = {fa.sign & fb.sign, 31'b0};
        else if (is_zero(a))
            sum = b;
        else if (is_zero(b))
            sum = a;
        else if (raw == '0)
            sum = '0;
        else if (exp_r >= 10'sd255)
            sum = {big.sign, 8'hFF, 23'b0};
        else if (exp_r <= 10'sd0)
            sum = {big.sign, 31'b0};
        else
            sum = {big.sign, exp_r[7:0], norm[26:4]};
    end

    assign unused_norm = ^{norm[27], norm[3:0]};

endmodule

// File: rtl/fp32_accumulator.sv
// Sums a stream of FP32 products into one value per vector and holds the
// result on a valid/ready output until consumed.
module fp32_accumulator
    import fp32_pkg::*;
#(
    parameter int MAX_LEN = 784,
    parameter int CNT_W   = 10
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [31:0]      in_data,
    input  logic             in_last,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      out_data,
    output logic [CNT_W-1:0] out_len,
    output logic             out_len_err
);

    localparam logic [0:0] ACCUM = 1'b0;
    localparam logic [0:0] HOLD  = 1'b1;

    logic [0:0]       state;
    logic [31:0]      acc;
    logic [CNT_W-1:0] cnt;
    logic [31:0]      add_a, sum;
    logic             end_vec;

    assign in_ready  = (state == ACCUM);
    assign out_valid = (state == HOLD);
    // First beat adds to +0 so a stale accumulator can never leak in.
    assign add_a     = (cnt == '0) ? 32'h0 : acc;
    assign end_vec   = in_last || (cnt == CNT_W'(MAX_LEN - 1));

    fp32_adder u_add (
        .a   (add_a),
        .b   (in_data),
        .sum (sum)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state       <= ACCUM;
            acc         <= '0;
            cnt         <= '0;
            out_data    <= '0;
            out_len     <= '0;
            out_len_err <= 1'b0;
        end else begin
            case (state)
                ACCUM: begin
                    if (in_valid) begin
                        if (end_vec) begin
                            out_data    <= sum;
                            out_len     <= cnt + 1'b1;
                            out_len_err <= ~in_last;
                            acc         <= '0;
                            cnt         <= '0;
                            state       <= HOLD;
                        end else begin
                            acc <= sum;
                            cnt <= cnt + 1'b1;
                        end
                    end
                end
                default: begin
                    if (out_ready)
                        state <= ACCUM;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fp32_accumulator.sv
// Directed table vectors, handshake/length/reset corner sequences and a
// randomised exact-arithmetic comparison against an integer reference.
module tb_fp32_accumulator;

    localparam int MAX_LEN = 784;
    localparam int CNT_W   = 10;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [31:0]      in_data = '0;
    logic             in_last = 1'b0;
    logic             out_valid;
    logic             out_ready = 1'b0;
    logic [31:0]      out_data;
    logic [CNT_W-1:0] out_len;
    logic             out_len_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    fp32_accumulator #(.MAX_LEN(MAX_LEN), .CNT_W(CNT_W)) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .in_last     (in_last),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_data    (out_data),
        .out_len     (out_len),
        .out_len_err (out_len_err)
    );

    typedef struct {
        int               n;
        logic [3:0][31:0] d;
        logic [31:0]      exp_data;
        int               exp_len;
        logic             exp_err;
    } vec_t;

    vec_t tbl[6];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic timeout(input string name);
        total++;
        bad++;
        $display("FAIL %s: timed out", name);
    endtask

    task automatic beat(input logic [31:0] d, input logic last, input int gap);
        int t;
        t = 0;
        repeat (gap) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        while (!in_ready && t < 2000) begin
            @(negedge clk);
            t++;
        end
        if (!in_ready) timeout("beat_accept");
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    task automatic result(input logic [31:0] ed, input int el, input logic ee,
                          input string nm, input int delay);
        int t;
        t = 0;
        @(negedge clk);
        while (!out_valid && t < 3000) begin
            @(negedge clk);
            t++;
        end
        if (!out_valid) begin
            timeout({nm, "_valid"});
        end else begin
            repeat (delay) @(negedge clk);
            chk({nm, "_data"}, out_data, ed);
            chk({nm, "_len"}, 32'(out_len), 32'(el));
            chk({nm, "_err"}, {31'b0, out_len_err}, {31'b0, ee});
            out_ready = 1'b1;
            @(posedge clk);
            #1;
            out_ready = 1'b0;
        end
    endtask

    // Value is u/16; all random traffic stays exactly representable.
    function automatic logic [31:0] to_fp(input int u);
        logic [31:0] r;
        int m, p;
        if (u == 0) return 32'h0;
        m = (u < 0) ? -u : u;
        p = 0;
        for (int i = 0; i < 31; i++)
            if (((m >> i) & 1) != 0) p = i;
        r[31]    = (u < 0);
        r[30:23] = 8'(p - 4 + 127);
        r[22:0]  = 23'((m << (23 - p)) & 32'h7FFFFF);
        return r;
    endfunction

    initial begin
        tbl[0] = '{3, {32'h0, 32'h3F000000, 32'h40000000, 32'h3F800000}, 32'h40600000, 3, 1'b0};
        tbl[1] = '{2, {32'h0, 32'h0, 32'hBF800000, 32'h3F800000}, 32'h00000000, 2, 1'b0};
        tbl[2] = '{2, {32'h0, 32'h0, 32'h7F7FFFFF, 32'h7F7FFFFF}, 32'h7F800000, 2, 1'b0};
        tbl[3] = '{3, {32'h0, 32'h3F800000, 32'hFF800000, 32'h7F800000}, 32'h7FC00000, 3, 1'b0};
        tbl[4] = '{1, {32'h0, 32'h0, 32'h0, 32'h40490FDB}, 32'h40490FDB, 1, 1'b0};
        tbl[5] = '{4, {32'h3F800000, 32'h00400000, 32'hC0000000, 32'h40400000}, 32'h40000000, 4, 1'b0};

        repeat (3) @(negedge clk);
        chk("rst_valid", {31'b0, out_valid}, 32'h0);
        chk("rst_data", out_data, 32'h0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rst_ready", {31'b0, in_ready}, 32'h1);
        chk("rst_len", 32'(out_len), 32'h0);
        chk("rst_err", {31'b0, out_len_err}, 32'h0);

        for (int v = 0; v < 6; v++) begin
            for (int i = 0; i < tbl[v].n; i++)
                beat(tbl[v].d[i], i == tbl[v].n - 1, 0);
            result(tbl[v].exp_data, tbl[v].exp_len, tbl[v].exp_err, $sformatf("tbl%0d", v), 0);
        end

        // Output backpressure: beats presented during HOLD must wait.
        beat(32'h3F800000, 1'b0, 0);
        beat(32'h40000000, 1'b1, 0);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = 32'h40000000;
        in_last  = 1'b0;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            chk("hold_ready", {31'b0, in_ready}, 32'h0);
            chk("hold_valid", {31'b0, out_valid}, 32'h1);
            chk("hold_data", out_data, 32'h40400000);
        end
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        chk("hs_ready", {31'b0, in_ready}, 32'h1);
        chk("hs_valid", {31'b0, out_valid}, 32'h0);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        beat(32'h3F800000, 1'b1, 0);
        result(32'h40400000, 2, 1'b0, "after_hold", 0);

        // Forced end at MAX_LEN, then in_last exactly on beat MAX_LEN.
        for (int i = 0; i < MAX_LEN; i++) beat(32'h3F800000, 1'b0, 0);
        result(32'h44440000, MAX_LEN, 1'b1, "maxlen", 0);
        for (int i = 0; i < MAX_LEN; i++) beat(32'h3F800000, i == MAX_LEN - 1, 0);
        result(32'h44440000, MAX_LEN, 1'b0, "maxlen_last", 0);

        // Reset mid-vector discards the partial sum.
        beat(32'h3F800000, 1'b0, 0);
        beat(32'h40000000, 1'b0, 0);
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'b0, out_valid}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        beat(32'h40400000, 1'b0, 0);
        beat(32'h40800000, 1'b1, 0);
        result(32'h40E00000, 2, 1'b0, "midrst", 0);

        for (int v = 0; v < 1000; v++) begin
            int n, units, term, k, j;
            n = int'($urandom_range(1, 8));
            units = 0;
            for (int i = 0; i < n; i++) begin
                k = int'($urandom_range(0, 30)) - 15;
                j = int'($urandom_range(0, 8));
                term = k * (1 << j);
                units += term;
                beat(to_fp(term), i == n - 1, int'($urandom_range(0, 2)));
            end
            result(to_fp(units), n, 1'b0, "rnd", int'($urandom_range(0, 3)));
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
